// File: rtl/qupls4_fu_credit_tracker.sv
// qupls4_fu_credit_tracker
//   Tracks the reservation-station occupancy of every functional unit and
//   produces the registered busy vector the dispatcher uses to stall.
//   Arrivals are counted from the dispatch slots and removals from fu_take.
//   Busy asserts HEADROOM entries early to cover dispatches already in flight.
//   Over- and underflow of the occupancy count set a sticky acct_err flag.
//   Optional feature: define QUPLS4_FU_PERF_EN to add per-unit busy-cycle
//   counters, which are read through perf_sel/perf_cnt.
module qupls4_fu_credit_tracker #(
  parameter int NFU      = 15,
  parameter int NDISP    = 4,
  parameter int RS_DEPTH = 4,
  parameter int HEADROOM = 1,
  parameter int CW       = $clog2(RS_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NDISP-1:0]    disp_v,
  input  logic [NDISP*4-1:0]  disp_fu,
  input  logic [NFU-1:0]      fu_take,
  input  logic [15:0]         fu_disable,
  input  logic                ovf_clr,
  output logic [15:0]         busy,
  output logic [NFU*CW-1:0]   occ,
  output logic                acct_err,
  input  logic [3:0]          perf_sel,
  output logic [31:0]         perf_cnt
);

  // The extra bits let the occupancy arithmetic hold the full range without
  // wrapping. The range is -1 to RS_DEPTH+NDISP.
  localparam int RW = CW + 3;

  logic [CW-1:0]  r_occ [NFU];
  logic [15:0]    r_busy;
  logic           r_acct_err;

  logic [CW-1:0]  w_occ_next [NFU];
  logic [15:0]    w_busy_next;
  logic [NFU-1:0] w_err;

  genvar gi;

  // Compute the next occupancy, an error indication and the busy bit for each unit.
  generate
    for (gi = 0; gi < NFU; gi++) begin : g_unit
      logic [RW-1:0]        w_inc;
      logic signed [RW-1:0] w_raw;

      // Count the valid dispatch slots that target this unit.
      always_comb begin
        w_inc = '0;
        for (int k = 0; k < NDISP; k++) begin
          if (disp_v[k] && (disp_fu[4*k +: 4] == 4'(gi))) begin
            w_inc = w_inc + {{(RW-1){1'b0}}, 1'b1};
          end
        end
      end

      assign w_raw = $signed({3'b000, r_occ[gi]}) + $signed(w_inc)
                   - $signed({{(RW-1){1'b0}}, fu_take[gi]});

      // Clamp to the range 0 to RS_DEPTH. A value outside that range is an
      // accounting error.
      always_comb begin
        w_err[gi]      = 1'b0;
        w_occ_next[gi] = w_raw[CW-1:0];
        if (w_raw[RW-1]) begin
          w_occ_next[gi] = '0;
          w_err[gi]      = 1'b1;
        end else if (w_raw > $signed(RW'(RS_DEPTH))) begin
          w_occ_next[gi] = CW'(RS_DEPTH);
          w_err[gi]      = 1'b1;
        end
      end

      assign w_busy_next[gi] = fu_disable[gi]
                             | (w_occ_next[gi] >= CW'(RS_DEPTH - HEADROOM));
      assign occ[CW*gi +: CW] = r_occ[gi];
    end

    // Codes that do not belong to any unit always read as busy.
    for (gi = NFU; gi < 16; gi++) begin : g_nounit
      assign w_busy_next[gi] = 1'b1;
    end
  endgenerate

`ifdef QUPLS4_FU_PERF_EN
  logic [31:0] r_perf [NFU];
`endif

  // Register the occupancy, busy and error state. A flush empties every
  // station and raises no error. Setting the error flag wins over a clear
  // in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NFU; f++) begin
        r_occ[f] <= '0;
      end
      r_busy     <= 16'hFFFF;
      r_acct_err <= 1'b0;
`ifdef QUPLS4_FU_PERF_EN
      for (int f = 0; f < NFU; f++) begin
        r_perf[f] <= '0;
      end
`endif
    end else begin
      if (flush) begin
        for (int f = 0; f < NFU; f++) begin
          r_occ[f] <= '0;
        end
        r_busy <= fu_disable | 16'h8000;
        if (ovf_clr) begin
          r_acct_err <= 1'b0;
        end
      end else begin
        for (int f = 0; f < NFU; f++) begin
          r_occ[f] <= w_occ_next[f];
        end
        r_busy <= w_busy_next;
        if (|w_err) begin
          r_acct_err <= 1'b1;
        end else if (ovf_clr) begin
          r_acct_err <= 1'b0;
        end
      end
`ifdef QUPLS4_FU_PERF_EN
      for (int f = 0; f < NFU; f++) begin
        if (r_busy[f]) begin
          r_perf[f] <= r_perf[f] + 32'd1;
        end
      end
`endif
    end
  end

  assign busy     = r_busy;
  assign acct_err = r_acct_err;

`ifdef QUPLS4_FU_PERF_EN
  // Read out the selected counter. Selects with no unit behind them read zero.
  always_comb begin
    perf_cnt = 32'd0;
    if (int'(perf_sel) < NFU) begin
      perf_cnt = r_perf[perf_sel];
    end
  end
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^perf_sel;
  assign perf_cnt          = 32'd0;
`endif

endmodule

// File: tb/tb_qupls4_fu_credit_tracker.sv
// Directed self-checking bench for qupls4_fu_credit_tracker.
module tb_qupls4_fu_credit_tracker;

  localparam int NFU = 15;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [3:0]    disp_v;
  logic [15:0]   disp_fu;
  logic [NFU-1:0] fu_take;
  logic [15:0]   fu_disable;
  logic          ovf_clr;
  logic [15:0]   busy;
  logic [NFU*CW-1:0] occ;
  logic          acct_err;
  logic [3:0]    perf_sel;
  logic [31:0]   perf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  qupls4_fu_credit_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_v     (disp_v),
    .disp_fu    (disp_fu),
    .fu_take    (fu_take),
    .fu_disable (fu_disable),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .occ        (occ),
    .acct_err   (acct_err),
    .perf_sel   (perf_sel),
    .perf_cnt   (perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [CW-1:0] occ_of(input int f);
    return occ[CW*f +: CW];
  endfunction

  task automatic idle();
    flush   = 1'b0;
    disp_v  = '0;
    disp_fu = 16'hFFFF;
    fu_take = '0;
    ovf_clr = 1'b0;
  endtask

  // Apply the current inputs across one rising edge. Outputs are sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] perf_base;

  initial begin
    rst        = 1'b0;
    fu_disable = '0;
    perf_sel   = 4'd2;
    idle();
    #23;
    // 1: reset state, then one idle edge after release
    check("rst_busy", 64'(busy), 64'hFFFF);
    check("rst_occ",  64'(occ), 64'h0);
    check("rst_err",  64'(acct_err), 64'h0);
    rst = 1'b1;
    cycle();
    check("idle_busy", 64'(busy), 64'h8000);

    // 2: three single dispatches to unit 0; busy sets when occ reaches 3
    disp_v = 4'b0001; disp_fu = 16'hFFF0;
    cycle();
    check("occ0_1", 64'(occ_of(0)), 64'd1);
    check("busy0_at1", 64'(busy[0]), 64'd0);
    cycle();
    check("occ0_2", 64'(occ_of(0)), 64'd2);
    check("busy0_at2", 64'(busy[0]), 64'd0);
    cycle();
    check("occ0_3", 64'(occ_of(0)), 64'd3);
    check("busy0_at3", 64'(busy[0]), 64'd1);
    idle();

    // 3: two dispatches plus one take in the same cycle net to +1
    disp_v = 4'b0011; disp_fu = 16'hFF44;
    cycle();
    check("occ4_2", 64'(occ_of(4)), 64'd2);
    fu_take = 15'(1 << 4);
    cycle();
    check("occ4_3", 64'(occ_of(4)), 64'd3);
    check("busy4", 64'(busy[4]), 64'd1);
    check("err_net", 64'(acct_err), 64'd0);
    idle();

    // 4: overflow, clearing the error, underflow, set priority over clear, ignored codes
    disp_v = 4'b1111; disp_fu = 16'h8888;
    cycle();
    check("occ8_4", 64'(occ_of(8)), 64'd4);
    check("err_full", 64'(acct_err), 64'd0);
    disp_v = 4'b0001; disp_fu = 16'hFFF8;
    cycle();
    check("occ8_sat", 64'(occ_of(8)), 64'd4);
    check("err_ovf", 64'(acct_err), 64'd1);
    idle(); ovf_clr = 1'b1;
    cycle();
    check("err_clr", 64'(acct_err), 64'd0);
    idle(); fu_take = 15'(1 << 9);
    cycle();
    check("occ9_0", 64'(occ_of(9)), 64'd0);
    check("err_udf", 64'(acct_err), 64'd1);
    idle(); ovf_clr = 1'b1; disp_v = 4'b0001; disp_fu = 16'hFFF8;
    cycle();
    check("err_setprio", 64'(acct_err), 64'd1);
    idle(); ovf_clr = 1'b1;
    cycle();
    check("err_clr2", 64'(acct_err), 64'd0);
    idle(); disp_v = 4'b1111; disp_fu = 16'hFFFF;
    cycle();
    check("code15_err", 64'(acct_err), 64'd0);
    check("code15_busy", 64'(busy), 64'h8111);

    // 5: fill units 0 to 3, then flush with a full dispatch in the same cycle
    idle(); disp_v = 4'b1111; disp_fu = 16'h3210;
    cycle();
    check("occ0_4", 64'(occ_of(0)), 64'd4);
    check("occ3_1", 64'(occ_of(3)), 64'd1);
    idle(); flush = 1'b1; disp_v = 4'b1111; disp_fu = 16'h3210; fu_disable = 16'h0004;
    cycle();
    check("flush_occ", 64'(occ), 64'h0);
    check("flush_busy", 64'(busy), 64'h8004);
    check("flush_err", 64'(acct_err), 64'd0);

    // 6: perf counter for unit 2 (busy through fu_disable for 10 cycles)
    idle(); fu_disable = 16'h0000;
    cycle();
    perf_base = perf_cnt;
    fu_disable = 16'h0004;
    repeat (10) cycle();
    fu_disable = 16'h0000;
    repeat (2) cycle();
`ifdef QUPLS4_FU_PERF_EN
    check("perf_delta", 64'(perf_cnt - perf_base), 64'd10);
    perf_sel = 4'd15;
    #1;
    check("perf_sel15", 64'(perf_cnt), 64'd0);
`else
    check("perf_base0", 64'(perf_base), 64'd0);
    check("perf_off", 64'(perf_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
